// File: rtl/vga_string_bank_pkg.sv
// rtl/vga_string_bank_pkg.sv - vga_string_pkg: phase encoding, amplitude width and 11-bit signed coordinate type
package vga_string_pkg;

  localparam int AMP_W = 3;

  typedef logic [AMP_W-1:0] amp_t;
  typedef logic signed [10:0] coord_t;

  // Quarter-cycle phases of the vibration; displacement is zero on both crossings.
  typedef enum logic [1:0] {
    PH_ZERO0 = 2'd0,
    PH_POS   = 2'd1,
    PH_ZERO2 = 2'd2,
    PH_NEG   = 2'd3
  } phase_e;

  function automatic coord_t phase_disp(input phase_e ph, input amp_t amp);
    coord_t d;
    d = '0;
    case (ph)
      PH_POS:  d = coord_t'(amp);
      PH_NEG:  d = -coord_t'(amp);
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vga_string_bank_if.sv
// rtl/vga_string_bank_if.sv - pixel coordinate in, per-string hit result out
interface vga_string_bank_if #(
  parameter int NUM_STRINGS = 6
);
  logic [9:0]             x;
  logic [9:0]             y;
  logic                   frame_start;
  logic [9:0]             x_q;
  logic [NUM_STRINGS-1:0] hit_vec;
  logic                   disp_out;

  modport master (
    output x, y, frame_start,
    input  x_q, hit_vec, disp_out
  );

  modport slave (
    input  x, y, frame_start,
    output x_q, hit_vec, disp_out
  );
endinterface

// File: rtl/vga_string_bank_voice.sv
// rtl/vga_string_bank_voice.sv - string_voice: one string's amp/phase state and displacement
// Amplitude decay is built only when STRING_DECAY_EN is defined.
module string_voice
  import vga_string_pkg::*;
#(
  parameter int MAX_AMP     = 4,
  parameter int DECAY_TICKS = 8
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  input  logic   pluck,
  input  logic   mute,
  output logic   vibrating,
  output coord_t disp
);

`ifdef STRING_DECAY_EN
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  typedef logic [DW-1:0] dcnt_t;
  localparam dcnt_t D_LAST = dcnt_t'(DECAY_TICKS - 1);
  dcnt_t dcnt, dcnt_n;
`endif

  amp_t   amp, amp_n;
  phase_e phase, phase_n;

  always_comb begin
    amp_n   = amp;
    phase_n = phase;
`ifdef STRING_DECAY_EN
    dcnt_n  = dcnt;
`endif
    if (mute) begin
      amp_n   = '0;
      phase_n = PH_ZERO0;
`ifdef STRING_DECAY_EN
      dcnt_n  = '0;
`endif
    end else if (pluck) begin
      // A re-pluck only restores amplitude; the phase keeps running.
      amp_n  = amp_t'(MAX_AMP);
`ifdef STRING_DECAY_EN
      dcnt_n = '0;
`endif
    end else if (tick && amp != '0) begin
      phase_n = phase_e'(phase + 2'd1);
`ifdef STRING_DECAY_EN
      if (dcnt == D_LAST) begin
        dcnt_n = '0;
        amp_n  = amp - amp_t'(1);
        if (amp == amp_t'(1)) phase_n = PH_ZERO0;
      end else begin
        dcnt_n = dcnt + dcnt_t'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amp   <= '0;
      phase <= PH_ZERO0;
`ifdef STRING_DECAY_EN
      dcnt  <= '0;
`endif
    end else begin
      amp   <= amp_n;
      phase <= phase_n;
`ifdef STRING_DECAY_EN
      dcnt  <= dcnt_n;
`endif
    end
  end

  assign vibrating = (amp != '0);
  assign disp      = phase_disp(phase, amp);

endmodule

// File: rtl/vga_string_bank.sv
// rtl/vga_string_bank.sv - vibrating string renderer: tick divider, per-string voices, frame shadow, row compare
// Amplitude decay in the voices is enabled with STRING_DECAY_EN.
module vga_string_bank
  import vga_string_pkg::*;
#(
  parameter int NUM_STRINGS = 6,
  parameter int Y_BASE      = 100,
  parameter int Y_PITCH     = 40,
  parameter int THICK       = 3,
  parameter int MAX_AMP     = 4,
  parameter int TICK_DIV    = 1666667,
  parameter int DECAY_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  vga_string_bank_if.slave       pix,
  input  logic [NUM_STRINGS-1:0] pluck,
  input  logic [NUM_STRINGS-1:0] mute,
  output logic [NUM_STRINGS-1:0] vibrating
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef logic [TW-1:0] tcnt_t;
  localparam tcnt_t T_LAST = tcnt_t'(TICK_DIV - 1);

  tcnt_t tick_cnt;
  logic  tick;

  assign tick = (tick_cnt == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + tcnt_t'(1);
  end

  coord_t disp   [NUM_STRINGS];
  coord_t shadow [NUM_STRINGS];

  for (genvar i = 0; i < NUM_STRINGS; i++) begin : g_voice
    string_voice #(
      .MAX_AMP     (MAX_AMP),
      .DECAY_TICKS (DECAY_TICKS)
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .pluck     (pluck[i]),
      .mute      (mute[i]),
      .vibrating (vibrating[i]),
      .disp      (disp[i])
    );
  end

  // Rendering sees displacements only as of the last frame_start, so a frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STRINGS; i++) shadow[i] <= '0;
    end else if (pix.frame_start) begin
      for (int i = 0; i < NUM_STRINGS; i++) shadow[i] <= disp[i];
    end
  end

  coord_t                 y_s;
  coord_t                 top_i;
  logic [NUM_STRINGS-1:0] hit_n;

  always_comb begin
    y_s   = coord_t'({1'b0, pix.y});
    top_i = '0;
    hit_n = '0;
    for (int i = 0; i < NUM_STRINGS; i++) begin
      top_i    = coord_t'(Y_BASE + i * Y_PITCH) + shadow[i];
      hit_n[i] = (y_s > top_i) && (y_s <= top_i + coord_t'(THICK));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix.hit_vec  <= '0;
      pix.disp_out <= 1'b0;
      pix.x_q      <= '0;
    end else begin
      pix.hit_vec  <= hit_n;
      pix.disp_out <= |hit_n;
      pix.x_q      <= pix.x;
    end
  end

endmodule

// File: tb/tb_vga_string_bank.sv
// tb/tb_vga_string_bank.sv - directed scoreboard bench for vga_string_bank
module tb_vga_string_bank;

  localparam int NS          = 6;
  localparam int Y_BASE      = 100;
  localparam int Y_PITCH     = 40;
  localparam int THICK       = 3;
  localparam int MAX_AMP     = 4;
  localparam int TICK_DIV    = 4;
  localparam int DECAY_TICKS = 2;
`ifdef STRING_DECAY_EN
  localparam int AMP3 = MAX_AMP - 1;
`else
  localparam int AMP3 = MAX_AMP;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [NS-1:0] pluck = '0;
  logic [NS-1:0] mute  = '0;
  logic [NS-1:0] vibrating;

  vga_string_bank_if #(.NUM_STRINGS(NS)) pix ();

  vga_string_bank #(
    .NUM_STRINGS (NS),
    .Y_BASE      (Y_BASE),
    .Y_PITCH     (Y_PITCH),
    .THICK       (THICK),
    .MAX_AMP     (MAX_AMP),
    .TICK_DIV    (TICK_DIV),
    .DECAY_TICKS (DECAY_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix       (pix.slave),
    .pluck     (pluck),
    .mute      (mute),
    .vibrating (vibrating)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] hv;
    logic          dout;
    logic [9:0]    xq;
  } exp_t;

  exp_t  sb     [$];
  string sb_tag [$];
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    tcnt       = 0;
  int    tick_total = 0;
  bit    ticked     = 1'b0;
  int    ex_sh [NS];
  int    t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    exp_t  e;
    string t;
    @(posedge clk);
    if (reset) begin
      ticked = (tcnt == TICK_DIV - 1);
      tcnt   = ticked ? 0 : tcnt + 1;
      if (ticked) tick_total++;
    end else begin
      ticked = 1'b0;
      tcnt   = 0;
    end
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      check({t, ".hit_vec"},  32'(pix.hit_vec),  32'(e.hv));
      check({t, ".disp_out"}, 32'(pix.disp_out), 32'(e.dout));
      check({t, ".x_q"},      32'(pix.x_q),      32'(e.xq));
    end
  endtask

  function automatic logic [NS-1:0] exp_hit(input int yy);
    logic [NS-1:0] h;
    h = '0;
    for (int i = 0; i < NS; i++) begin
      int top;
      top  = Y_BASE + i * Y_PITCH + ex_sh[i];
      h[i] = (yy > top) && (yy <= top + THICK);
    end
    return h;
  endfunction

  task automatic send(input string tag, input int yy);
    exp_t e;
    pix.y  = 10'(yy);
    pix.x  = 10'(yy * 3 + 7);
    e.hv   = exp_hit(yy);
    e.dout = |e.hv;
    e.xq   = pix.x;
    sb.push_back(e);
    sb_tag.push_back(tag);
    step();
  endtask

  task automatic clear_sh();
    for (int i = 0; i < NS; i++) ex_sh[i] = 0;
  endtask

  task automatic frame();
    if (tcnt == TICK_DIV - 1) step();
    pix.frame_start = 1'b1;
    step();
    pix.frame_start = 1'b0;
  endtask

  task automatic pulse_pluck(input int i);
    if (tcnt == TICK_DIV - 1) step();
    pluck[i] = 1'b1;
    step();
    pluck = '0;
  endtask

  task automatic ticks_until(input int base, input int k);
    int guard;
    guard = 0;
    while ((tick_total - base) < k && guard < 20000) begin
      step();
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pix.x           = '0;
    pix.y           = '0;
    pix.frame_start = 1'b0;
    clear_sh();

    repeat (3) step();
    check("rst.hit_vec",   32'(pix.hit_vec),  32'd0);
    check("rst.disp_out",  32'(pix.disp_out), 32'd0);
    check("rst.vibrating", 32'(vibrating),    32'd0);

    reset = 1'b1;
    frame();
    send("rest.y101", 101);
    send("rest.y100", 100);
    send("rest.y103", 103);
    send("rest.y104", 104);
    send("rest.y141", 141);

    pulse_pluck(0);
    t0 = tick_total;
    check("pluck0.vib", 32'(vibrating[0]), 32'd1);
    ticks_until(t0, 1);
    frame();
    ex_sh[0] = MAX_AMP;
    send("ph1.y104", 104);
    send("ph1.y105", 105);
    send("ph1.y107", 107);
    send("ph1.y108", 108);

    ticks_until(t0, 2);
    send("tear.y105", 105);
    send("tear.y101", 101);

    ticks_until(t0, 3);
    frame();
    ex_sh[0] = -AMP3;
    send("ph3.y96",  96);
    send("ph3.y97",  97);
    send("ph3.y99",  99);
    send("ph3.y100", 100);

    mute[1]  = 1'b1;
    pluck[1] = 1'b1;
    step();
    mute  = '0;
    pluck = '0;
    check("mutepluck.vib1", 32'(vibrating[1]), 32'd0);

    mute[0] = 1'b1;
    step();
    mute = '0;
    check("mute0.vib0", 32'(vibrating[0]), 32'd0);

`ifdef STRING_DECAY_EN
    pulse_pluck(2);
    t0 = tick_total;
    check("decay.start", 32'(vibrating[2]), 32'd1);
    ticks_until(t0, 7);
    check("decay.t7", 32'(vibrating[2]), 32'd1);
    ticks_until(t0, 8);
    check("decay.t8", 32'(vibrating[2]), 32'd0);
    pulse_pluck(2);
    t0 = tick_total;
    ticks_until(t0, 1);
    frame();
    clear_sh();
    ex_sh[2] = MAX_AMP;
    send("decay.y185", 185);
    send("decay.y184", 184);
    send("decay.y141", 141);
`else
    pulse_pluck(5);
    t0 = tick_total;
    ticks_until(t0, 100);
    check("nodecay.t100", 32'(vibrating[5]), 32'd1);
    ticks_until(t0, 101);
    frame();
    clear_sh();
    ex_sh[5] = MAX_AMP;
    send("nodecay.y305", 305);
    send("nodecay.y304", 304);
    send("nodecay.y141", 141);
    mute[5] = 1'b1;
    step();
    mute = '0;
    check("mute5.vib5", 32'(vibrating[5]), 32'd0);
`endif

    mute = '1;
    step();
    mute = '0;
    check("muteall.vib", 32'(vibrating), 32'd0);

    pulse_pluck(3);
    t0 = tick_total;
    ticks_until(t0, 1);
    frame();
    clear_sh();
    ex_sh[3] = MAX_AMP;
    send("s3.y225", 225);
    check("s3.vib", 32'(vibrating[3]), 32'd1);

    reset = 1'b0;
    #2;
    check("midrst.hit_vec",   32'(pix.hit_vec),  32'd0);
    check("midrst.disp_out",  32'(pix.disp_out), 32'd0);
    check("midrst.vibrating", 32'(vibrating),    32'd0);
    repeat (2) step();
    reset = 1'b1;
    clear_sh();
    frame();
    send("post.y101", 101);
    send("post.y221", 221);
    check("post.vib", 32'(vibrating), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
